// File: rtl/sgpio_slice.sv
// sgpio_slice: multi-lane SGPIO serial/parallel slice with a shared FIFO.
// RX mode assembles LSB-first lane bits into words queued for the fabric;
// TX mode takes fabric words from the same FIFO and shifts them out gaplessly.
module sgpio_slice #(
  parameter int LANES = 1,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dir,
  input  logic                       shift_en_n,
  input  logic [LANES-1:0]           sin,
  output logic [LANES-1:0]           sout,
  output logic [LANES*WIDTH-1:0]     rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  input  logic [LANES*WIDTH-1:0]     tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic                       underrun,
  input  logic                       clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = LANES * WIDTH;
  localparam int CW = $clog2(WIDTH);

  // Registered state
  logic          dir_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sh;
  logic          loaded;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  // Next-state and control
  logic          en;
  logic          flush;
  logic          mode_ok;
  logic          empty;
  logic          full;
  logic          last;
  logic [W-1:0]  head;
  logic [W-1:0]  sh_rx;
  logic [W-1:0]  sh_tx;
  logic [W-1:0]  sh_d;
  logic [CW-1:0] cnt_d;
  logic          loaded_d;
  logic          push;
  logic          pop;
  logic [W-1:0]  push_data;
  logic          ovr_set;
  logic          und_set;

  // FIFO status and port handshakes, all from registered pointers and mode
  always_comb begin
    en       = ~shift_en_n;
    flush    = (dir != dir_q);
    mode_ok  = ~flush;
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    last     = (cnt == CW'(WIDTH - 1));
    head     = mem[rd_ptr[AW-1:0]];
    rx_data  = head;
    // Handshakes are withheld during a flush cycle, since any transfer
    // in that cycle would be discarded anyway.
    rx_valid = ~dir & mode_ok & ~empty;
    tx_ready = dir & mode_ok & ~full;
    level    = wr_ptr - rd_ptr;
  end

  // Per-lane shift candidates: RX shifts sin in at the top, TX shifts 0 in
  always_comb begin
    sh_rx = '0;
    sh_tx = '0;
    for (int l = 0; l < LANES; l++) begin
      sh_rx[l*WIDTH +: WIDTH] = {sin[l], sh[l*WIDTH+1 +: WIDTH-1]};
      sh_tx[l*WIDTH +: WIDTH] = {1'b0,   sh[l*WIDTH+1 +: WIDTH-1]};
    end
  end

  // Serial outputs: lane LSB in TX mode, held low in RX mode
  always_comb begin
    sout = '0;
    if (dir_q) begin
      for (int l = 0; l < LANES; l++) sout[l] = sh[l*WIDTH];
    end
  end

  // Shifter / counter / FIFO control for both modes, flush overrides all
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    sh_d      = sh;
    cnt_d     = cnt;
    loaded_d  = loaded;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = sh_rx;
    ovr_set   = 1'b0;
    und_set   = 1'b0;
    if (!dir_q) begin
      pop = rx_valid & rx_ready;
      if (en) begin
        sh_d  = sh_rx;
        cnt_d = last ? '0 : cnt + CW'(1);
        if (last) begin
          // A full FIFO still takes the word if the fabric pops this cycle.
          if (!full || pop) push = 1'b1;
          else              ovr_set = 1'b1;
        end
      end
    end else begin
      push      = tx_valid & tx_ready;
      push_data = tx_data;
      if (!loaded) begin
        if (!empty) begin
          sh_d     = head;
          pop      = 1'b1;
          loaded_d = 1'b1;
          cnt_d    = '0;
        end
      end else if (en) begin
        if (last) begin
          cnt_d = '0;
          if (!empty) begin
            // Reload on the last bit keeps the wire gapless.
            sh_d = head;
            pop  = 1'b1;
          end else begin
            sh_d     = '0;
            loaded_d = 1'b0;
            und_set  = 1'b1;
          end
        end else begin
          sh_d  = sh_tx;
          cnt_d = cnt + CW'(1);
        end
      end
    end
    if (flush) begin
      sh_d     = '0;
      cnt_d    = '0;
      loaded_d = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      ovr_set  = 1'b0;
      und_set  = 1'b0;
    end
  end

  // Control state registers
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      loaded   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dir_q    <= dir;
      cnt      <= cnt_d;
      sh       <= sh_d;
      loaded   <= loaded_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + (AW+1)'(push);
        rd_ptr <= rd_ptr + (AW+1)'(pop);
      end
      // A set in the same cycle as clear_flags wins.
      overrun  <= ovr_set | (overrun  & ~clear_flags);
      underrun <= und_set | (underrun & ~clear_flags);
    end
  end

  // FIFO storage write
  // NOTE: the FIFO array has no reset; the pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_sgpio_slice.sv
// Directed self-checking bench for sgpio_slice: RX assembly, enable gaps,
// overrun, gapless TX, flag priority, mode flush, async reset, two lanes.
module tb_sgpio_slice;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dir;
  logic        shift_en_n;
  logic [0:0]  sin;
  logic [0:0]  sout;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  level;
  logic        overrun;
  logic        underrun;
  logic        clear_flags;

  // Second instance: two lanes, RX only
  logic        dir2;
  logic        shift_en_n2;
  logic [1:0]  sin2;
  logic [1:0]  sout2;
  logic [15:0] rx_data2;
  logic        rx_valid2;
  logic        rx_ready2;
  logic [15:0] tx_data2;
  logic        tx_valid2;
  logic        tx_ready2;
  logic [2:0]  level2;
  logic        overrun2;
  logic        underrun2;
  logic        clear_flags2;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  rx_bits  = 8'h4D;
  logic [15:0] tx_bits  = 16'h3CA5;

  always #5 clk = ~clk;

  sgpio_slice #(.LANES(1), .WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .dir(dir), .shift_en_n(shift_en_n),
    .sin(sin), .sout(sout), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .level(level), .overrun(overrun),
    .underrun(underrun), .clear_flags(clear_flags)
  );

  sgpio_slice #(.LANES(2), .WIDTH(8), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .dir(dir2), .shift_en_n(shift_en_n2),
    .sin(sin2), .sout(sout2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .level(level2), .overrun(overrun2),
    .underrun(underrun2), .clear_flags(clear_flags2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift one 8-bit word LSB-first into lane 0, one bit per negedge
  task automatic send_rx_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sin        = w[i];
      shift_en_n = 1'b0;
    end
  endtask

  task automatic pop_rx();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dir = 1'b0; shift_en_n = 1'b1; sin = '0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0; clear_flags = 1'b0;
    dir2 = 1'b0; shift_en_n2 = 1'b1; sin2 = '0; rx_ready2 = 1'b0;
    tx_data2 = '0; tx_valid2 = 1'b0; clear_flags2 = 1'b0;

    // Reset state
    #1;
    check("rst_sout",     32'(sout),     32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RX basic: 1,0,1,1,0,0,1,0 -> 0x4D, valid right after the 8th shift edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) check("rx_basic_valid_early", 32'(rx_valid), 32'd0);
      sin        = rx_bits[i];
      shift_en_n = 1'b0;
    end
    @(negedge clk);
    shift_en_n = 1'b1;
    check("rx_basic_valid", 32'(rx_valid), 32'd1);
    check("rx_basic_data",  32'(rx_data),  32'h4D);
    check("rx_basic_level", 32'(level),    32'd1);
    check("rx_sout_low",    32'(sout),     32'd0);
    pop_rx();
    check("rx_pop_level", 32'(level),    32'd0);
    check("rx_pop_valid", 32'(rx_valid), 32'd0);

    // RX enable gaps: 4 bits, 3 idle cycles, 4 bits; valid only after cycle 11
    begin
      int b = 0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k > 1)
          check($sformatf("rx_gap_valid_c%0d", k-1), 32'(rx_valid), 32'(k-1 == 11));
        if (k <= 11 && (k <= 4 || k >= 8)) begin
          sin        = rx_bits[b];
          shift_en_n = 1'b0;
          b++;
        end else begin
          shift_en_n = 1'b1;
        end
      end
    end
    check("rx_gap_data", 32'(rx_data), 32'h4D);
    pop_rx();

    // RX overrun: five words with no reads
    for (int w = 1; w <= 4; w++) send_rx_word(8'(w));
    @(negedge clk);
    shift_en_n = 1'b1;
    check("ovr_level4",    32'(level),   32'd4);
    check("ovr_not_yet",   32'(overrun), 32'd0);
    send_rx_word(8'h05);
    @(negedge clk);
    shift_en_n = 1'b1;
    check("ovr_level_sat", 32'(level),   32'd4);
    check("ovr_set",       32'(overrun), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk);
      check($sformatf("ovr_read%0d", w), 32'(rx_data), 32'(w));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    check("ovr_drained", 32'(level), 32'd0);
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Mid-word dir toggle: leave a word queued, 4 partial bits, toggle, fresh word
    send_rx_word(8'h4D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sin = 1'b1;
    end
    @(negedge clk);
    check("flush_pre_level", 32'(level), 32'd1);
    shift_en_n = 1'b1;
    dir        = 1'b1;
    #1;
    check("flush_no_tx_ready", 32'(tx_ready), 32'd0);
    check("flush_no_rx_valid", 32'(rx_valid), 32'd0);
    @(negedge clk);
    dir = 1'b0;
    @(negedge clk);
    check("flush_level", 32'(level), 32'd0);
    check("flush_ovr_kept", 32'(overrun), 32'd0);
    send_rx_word(8'h96);
    @(negedge clk);
    shift_en_n = 1'b1;
    check("flush_fresh_data",  32'(rx_data), 32'h96);
    check("flush_fresh_level", 32'(level),   32'd1);

    // TX gapless: push 0xA5 then 0x3C, continuous enable
    @(negedge clk);
    dir = 1'b1;
    @(negedge clk);
    check("tx_ready_up",   32'(tx_ready), 32'd1);
    check("tx_flushed_lv", 32'(level),    32'd0);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    check("tx_level1", 32'(level), 32'd1);
    check("tx_sout_idle", 32'(sout), 32'd0);
    tx_data    = 8'h3C;
    shift_en_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_valid = 1'b0;
        check("tx_level_after_load", 32'(level), 32'd1);
      end
      check($sformatf("tx_bit%0d", k), 32'(sout), 32'(tx_bits[k]));
    end
    @(negedge clk);
    check("tx_underrun", 32'(underrun), 32'd1);
    check("tx_sout_zero", 32'(sout),    32'd0);

    // Flag priority: clear first, then clear again on the cycle underrun sets
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("und_cleared", 32'(underrun), 32'd0);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("tx81_bit%0d", k), 32'(sout), 32'((8'h81 >> k) & 8'h01));
    end
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("set_beats_clear", 32'(underrun), 32'd1);
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("und_cleared2", 32'(underrun), 32'd0);

    // Async reset mid-TX word
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h0F;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tx_mid_sout",  32'(sout),  32'd1);
    check("tx_mid_level", 32'(level), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sout",     32'(sout),     32'd0);
    check("arst_tx_ready", 32'(tx_ready), 32'd0);
    check("arst_level",    32'(level),    32'd0);
    @(negedge clk);
    shift_en_n = 1'b1;
    rst_n      = 1'b1;
    @(negedge clk);
    check("arst_tx_ready_back", 32'(tx_ready), 32'd1);
    check("arst_no_underrun",   32'(underrun), 32'd0);
    check("arst_sout_idle",     32'(sout),     32'd0);

    // Two lanes: lane0 constant 1, lane1 toggling from 1 -> 0x55FF
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sin2        = {((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1};
      shift_en_n2 = 1'b0;
    end
    @(negedge clk);
    shift_en_n2 = 1'b1;
    check("lane2_valid", 32'(rx_valid2), 32'd1);
    check("lane2_data",  32'(rx_data2),  32'h55FF);
    check("lane2_sout",  32'(sout2),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sgpio_slice.md
# sgpio_slice

Parametrised multi-lane SGPIO serial/parallel slice for the iCE40 firmware. It shifts LSB-first serial data on `LANES` pins, gated by an active-low shift enable. It runs in one of two modes:
- **RX mode:** assembles `LANES*WIDTH`-bit words into a `DEPTH`-entry FIFO, drained through a valid/ready port.
- **TX mode:** accepts words through a valid/ready port and serialises them gaplessly.

It sits between the SGPIO pins and the fabric-side sample logic.

## Interface
- `LANES`, 1: number of serial lanes.
- `WIDTH`, 8: bits per lane per word (≥2).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `clk`  in  1: the one clock. All state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `dir`  in  1: mode select. 0 = RX (pins→fabric), 1 = TX (fabric→pins).
- `shift_en_n`  in  1: active-low shift enable. Low = one bit shifted per lane this cycle.
- `sin`  in  LANES: serial inputs, bit l = lane l.
- `sout`  out  LANES: serial outputs, registered.
- `rx_data`  out  LANES*WIDTH: head FIFO word in RX mode.
- `rx_valid`  out  1: asserted when `dir==0` and FIFO non-empty.
- `rx_ready`  in  1: fabric accepts `rx_data`.
- `tx_data`  in  LANES*WIDTH: word to transmit.
- `tx_valid`  in  1: `tx_data` valid.
- `tx_ready`  out  1: asserted when `dir==1` and FIFO not full.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `overrun`  out  1: sticky. Set when an RX word is dropped.
- `underrun`  out  1: sticky. Set when TX runs dry.
- `clear_flags`  in  1: one-cycle pulse that clears `overrun` and `underrun`.

## Operation
- **Lane mapping.** Word bits `[l*WIDTH +: WIDTH]` belong to lane l. Bit 0 of each slice is first on the wire.
- **Shared FIFO.** One FIFO serves both modes:
  - RX: the shifter writes and the port reads.
  - TX: the port writes and the shifter reads.
- **FIFO push rule.** A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- **Bit counter.** `cnt` runs 0..WIDTH-1. It advances only on enabled cycles and wraps to 0.
- **RX:**
  - Each enabled cycle, per lane: `sh <= {sin[l], sh[WIDTH-1:1]}`.
  - On the enabled cycle with `cnt==WIDTH-1`, the assembled word (including the current `sin`) is pushed.
  - If that push is not accepted, the word is dropped and `overrun` is set. The shifter continues regardless.
  - `sout` is held at 0.
- **RX pop:** occurs on `rx_valid & rx_ready`.
- **TX:**
  - A `loaded` flag tracks whether the shifter holds a word.
  - When `loaded==0` and the FIFO is non-empty: at the next edge, load the head word (independent of enable), pop it, set `loaded=1` and `cnt=0`.
  - When `loaded==1` and enabled: shift right, filling 0, and advance `cnt`.
  - At `cnt==WIDTH-1`, if the FIFO is non-empty, load the next word and pop it, so there is no gap.
  - At `cnt==WIDTH-1` with the FIFO empty: clear the shifter to 0, set `loaded=0`, set `underrun`.
  - `sout[l]` = `sh_l[0]`.
- **TX push:** occurs on `tx_valid & tx_ready`.
- **Flags:** if a flag set and `clear_flags` occur in the same cycle, the set wins.
- **Mode change.** `dir` is registered into `dir_q`. On any cycle where `dir != dir_q`, a synchronous flush occurs:
  - FIFO emptied, `cnt=0`, shifters 0, `loaded=0`.
  - Pushes and pops in that cycle are discarded.
  - Flags are preserved.
- **Reset.** Asserting `rst_n` mid-word discards all state. Any partial word is lost, with no flag.

## Timing
- **Reset values:** `sout=0`, `rx_valid=0`, `tx_ready=0`, `level=0`, `overrun=0`, `underrun=0`, `cnt=0`, `dir_q=0`, `loaded=0`.
- **Port derivation:** `rx_valid`, `tx_ready` and `level` derive from registered pointers.
- **RX latency:** `rx_valid` rises 1 cycle after the edge that shifts the WIDTH-th bit, when the FIFO was empty.
- **TX start latency:**
  - `tx_valid` sampled at edge N → word in FIFO after edge N.
  - Loaded into the shifter at edge N+1 → first bit on `sout` after edge N+1.
- **TX cadence:** continuous enable gives exactly WIDTH cycles per word, back-to-back, with no idle bit while the FIFO has data.
- **Enable gaps:** `shift_en_n` high freezes `cnt`, the shifters and `sout`.

## Test plan
All scenarios use LANES=1, WIDTH=8, DEPTH=4 unless stated.
- **RX basic:** `dir=0`, continuous enable, `sin` = 1,0,1,1,0,0,1,0 → `rx_data=8'h4D`; `rx_valid` rises 1 cycle after the 8th shift.
- **RX enable gaps:** same bits as RX basic, `shift_en_n` high for 3 cycles after bit 3 → `rx_data=8'h4D`, valid 3 cycles later than RX basic.
- **RX overrun:** `rx_ready=0`, 5 words 0x01..0x05 → `level=4`, `overrun=1`; reads return 0x01..0x04 in order; `clear_flags` → `overrun=0`.
- **TX gapless:** push 0xA5 then 0x3C, continuous enable → `sout` = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with no gap; then `underrun=1` and `sout=0`.
- **Two lanes:** LANES=2, lane0 `sin` constant 1, lane1 toggling starting at 1 → `rx_data=16'h55FF`.
- **Mid-word disturbance:** toggle `dir` after 4 RX bits → `level=0` and the next word is assembled from fresh bits. Separately, `rst_n` low mid-TX-word → `sout=0` and `tx_ready=0` immediately, without waiting for a clock edge.
